systolic_array_load_sequencer: RTL and testbench



---
 rtl/systolic_array_pkg.sv | 16 +
 rtl/systolic_array_load_sequencer.sv | 175 +++++++++++++++++
 tb/tb_systolic_array_load_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/systolic_array_pkg.sv
// Shared defaults and state encoding for the systolic-array load path.
package systolic_array_pkg;

    localparam int SA_ARRAY_DIM = 4;
    localparam int SA_DATA_W    = 16;
    localparam int SA_ADDR_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LD_W = 3'd1,
        ST_LD_I = 3'd2,
        ST_LD_P = 3'd3,
        ST_DONE = 3'd4
    } sa_state_e;

endpackage

// File: rtl/systolic_array_load_sequencer.sv
// Streams weight, input and (with SA_PARTIALS_EN) partial-sum rows from memory into the array.
// Latency: 2 cycles per row (request, strobe) plus one DONE cycle.
// Backpressure: input/partial requests wait for fifo_has_space; weight loads are never gated.
module systolic_array_load_sequencer
    import systolic_array_pkg::*;
#(
    parameter int ARRAY_DIM = SA_ARRAY_DIM,
    parameter int DATA_W    = SA_DATA_W,
    parameter int ADDR_W    = SA_ADDR_W
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          start,
    input  logic                          load_partials,
    input  logic [ADDR_W-1:0]             base_addr,
    input  logic                          fifo_has_space,
    input  logic                          mem_rvalid,
    input  logic [ARRAY_DIM*DATA_W-1:0]   mem_rdata,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          weight_en,
    output logic                          input_en,
    output logic                          partial_en,
    output logic [$clog2(ARRAY_DIM)-1:0]  row_en,
    output logic [ARRAY_DIM*DATA_W-1:0]   array_in,
    output logic                          busy,
    output logic                          done
);

    localparam int                ROW_W    = $clog2(ARRAY_DIM);
    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ARRAY_DIM - 1);
    localparam logic [ADDR_W-1:0] OFF_I    = ADDR_W'(ARRAY_DIM);
    localparam logic [ADDR_W-1:0] OFF_P    = ADDR_W'(2 * ARRAY_DIM);

    sa_state_e                     state_q, state_d;
    logic [ROW_W-1:0]              row_q, row_d;
    logic [ADDR_W-1:0]             base_q, base_d;
    logic                          lp_q, lp_d;
    logic                          req_q, req_d;
    logic [ADDR_W-1:0]             addr_q, addr_d;
    logic                          wen_q, wen_d;
    logic                          ien_q, ien_d;
    logic                          pen_q, pen_d;
    logic [ROW_W-1:0]              row_en_q, row_en_d;
    logic [ARRAY_DIM*DATA_W-1:0]   data_q, data_d;
    logic                          done_q, done_d;
    logic                          try_req;
    logic [ADDR_W-1:0]             phase_off;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        base_d    = base_q;
        lp_d      = lp_q;
        req_d     = req_q;
        addr_d    = addr_q;
        wen_d     = 1'b0;
        ien_d     = 1'b0;
        pen_d     = 1'b0;
        row_en_d  = row_en_q;
        data_d    = data_q;
        done_d    = 1'b0;
        try_req   = 1'b0;
        phase_off = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LD_W;
                    row_d   = '0;
                    base_d  = base_addr;
`ifdef SA_PARTIALS_EN
                    lp_d    = load_partials;
`else
                    lp_d    = 1'b0;
`endif
                    req_d   = 1'b1;
                    addr_d  = base_addr;
                end
            end
            ST_LD_W, ST_LD_I, ST_LD_P: begin
                if (req_q) begin
                    // The request is held until memory answers; the row is presented next cycle.
                    if (mem_rvalid) begin
                        req_d    = 1'b0;
                        data_d   = mem_rdata;
                        row_en_d = row_q;
                        wen_d    = (state_q == ST_LD_W);
                        ien_d    = (state_q == ST_LD_I);
                        pen_d    = (state_q == ST_LD_P);
                    end
                end else if (wen_q || ien_q || pen_q) begin
                    try_req = 1'b1;
                    if (row_q == LAST_ROW) begin
                        row_d = '0;
                        case (state_q)
                            ST_LD_W: state_d = ST_LD_I;
                            ST_LD_I: state_d = lp_q ? ST_LD_P : ST_DONE;
                            default: state_d = ST_DONE;
                        endcase
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    try_req = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_LD_I: phase_off = OFF_I;
            ST_LD_P: phase_off = OFF_P;
            default: phase_off = '0;
        endcase

        if (try_req) begin
            if (state_d == ST_DONE) begin
                done_d = 1'b1;
            end else if (state_d == ST_LD_W || fifo_has_space) begin
                req_d  = 1'b1;
                addr_d = base_q + phase_off + ADDR_W'(row_d);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            row_q    <= '0;
            base_q   <= '0;
            lp_q     <= 1'b0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            wen_q    <= 1'b0;
            ien_q    <= 1'b0;
            pen_q    <= 1'b0;
            row_en_q <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            base_q   <= base_d;
            lp_q     <= lp_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            wen_q    <= wen_d;
            ien_q    <= ien_d;
            pen_q    <= pen_d;
            row_en_q <= row_en_d;
            data_q   <= data_d;
            done_q   <= done_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_addr  = addr_q;
    assign weight_en = wen_q;
    assign input_en  = ien_q;
    assign row_en    = row_en_q;
    assign array_in  = data_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

`ifdef SA_PARTIALS_EN
    assign partial_en = pen_q;
`else
    logic unused_partials;
    assign partial_en      = 1'b0;
    assign unused_partials = ^{pen_q, load_partials};
`endif

endmodule

// File: tb/tb_systolic_array_load_sequencer.sv
// Directed bench for the load sequencer with a zero-wait memory model.
module tb_systolic_array_load_sequencer;

`ifdef SA_PARTIALS_EN
    localparam bit PARTIALS_ON = 1'b1;
`else
    localparam bit PARTIALS_ON = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic        load_partials;
    logic [15:0] base_addr;
    logic        fifo_has_space;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        weight_en;
    logic        input_en;
    logic        partial_en;
    logic [1:0]  row_en;
    logic [63:0] array_in;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    systolic_array_load_sequencer #(.ARRAY_DIM(4), .DATA_W(16), .ADDR_W(16)) dut (
        .CLK(CLK), .RST(RST), .start(start), .load_partials(load_partials),
        .base_addr(base_addr), .fifo_has_space(fifo_has_space),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .weight_en(weight_en), .input_en(input_en), .partial_en(partial_en),
        .row_en(row_en), .array_in(array_in), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    function automatic logic [63:0] pat(input logic [15:0] a);
        logic [15:0] inc;
        inc = a + 16'd1;
        return {a, ~a, a ^ 16'hA5A5, inc};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req"},    {63'd0, mem_req}, 64'd0);
        check({tag, "_addr"},   {48'd0, mem_addr}, 64'd0);
        check({tag, "_strb"},   {61'd0, weight_en, input_en, partial_en}, 64'd0);
        check({tag, "_row"},    {62'd0, row_en}, 64'd0);
        check({tag, "_data"},   array_in, 64'd0);
        check({tag, "_busy"},   {63'd0, busy}, 64'd0);
        check({tag, "_done"},   {63'd0, done}, 64'd0);
    endtask

    // Runs one sequence; block stalls the FIFO on entry to LD_I, extra pulses start
    // mid-sequence, rst_at >= 0 aborts with reset in that cycle.
    task automatic run_seq(input logic [15:0] base, input logic lp, input bit block,
                           input bit extra, input int rst_at);
        logic [15:0] addrs[$];
        int          kinds[$];
        int          rows[$];
        logic [63:0] datas[$];
        int          done_cyc;
        int          nrows;
        int          exp_done;
        logic [15:0] e;
        done_cyc = -1;

        @(posedge CLK); #1;
        start = 1'b1; base_addr = base; load_partials = lp; mem_rvalid = 1'b0;
        for (int c = 1; c <= 80 && done_cyc < 0; c++) begin
            @(posedge CLK); #1;
            start = 1'b0; base_addr = 16'h0000;
            if (weight_en || input_en || partial_en) begin
                check("onehot", 64'(weight_en) + 64'(input_en) + 64'(partial_en), 64'd1);
                check("strb_noreq", {63'd0, mem_req}, 64'd0);
                kinds.push_back(weight_en ? 0 : (input_en ? 1 : 2));
                rows.push_back(int'(row_en));
                datas.push_back(array_in);
            end
            if (mem_req) addrs.push_back(mem_addr);
            if (done) done_cyc = c;
            if (block && c >= 9 && c <= 13) check("gate_req", {63'd0, mem_req}, 64'd0);
            if (c == rst_at) begin
                check("rst_pending", {63'd0, mem_req}, 64'd1);
                check("rst_pend_addr", {48'd0, mem_addr}, {48'd0, base + 16'd6});
                RST = 1'b1; mem_rvalid = 1'b0;
                @(posedge CLK); #1;
                check_idle_outputs("rst");
                RST = 1'b0; mem_rvalid = 1'b1; mem_rdata = pat(16'hBEEF);
                @(posedge CLK); #1;
                check("late_rvalid_strb", {61'd0, weight_en, input_en, partial_en}, 64'd0);
                check("late_rvalid_busy", {63'd0, busy}, 64'd0);
                check("late_rvalid_req", {63'd0, mem_req}, 64'd0);
                mem_rvalid = 1'b0;
                return;
            end
            mem_rvalid = mem_req;
            mem_rdata  = mem_req ? pat(mem_addr) : 64'd0;
            fifo_has_space = !(block && c >= 8 && c <= 12);
            if (extra && c == 3) begin
                start = 1'b1; base_addr = 16'h1234;
            end
        end
        mem_rvalid = 1'b0;
        if (done_cyc < 0) check("timeout", 64'd0, 64'd1);

        nrows    = (lp && PARTIALS_ON) ? 12 : 8;
        exp_done = 2 * nrows + 1 + (block ? 5 : 0);
        check("done_cycle", 64'(done_cyc), 64'(exp_done));
        check("n_addr", 64'(addrs.size()), 64'(nrows));
        check("n_strobe", 64'(kinds.size()), 64'(nrows));
        for (int k = 0; k < nrows && k < addrs.size(); k++) begin
            e = base + 16'(k);
            check($sformatf("addr%0d", k), {48'd0, addrs[k]}, {48'd0, e});
        end
        for (int k = 0; k < nrows && k < kinds.size(); k++) begin
            e = base + 16'(k);
            check($sformatf("kind%0d", k), 64'(kinds[k]), 64'(k / 4));
            check($sformatf("row%0d", k), 64'(rows[k]), 64'(k % 4));
            check($sformatf("data%0d", k), datas[k], pat(e));
        end

        @(posedge CLK); #1;
        check("done_pulse", {63'd0, done}, 64'd0);
        check("idle_busy", {63'd0, busy}, 64'd0);
        check("hold_row", {62'd0, row_en}, 64'd3);
        e = base + 16'(nrows - 1);
        check("hold_data", array_in, pat(e));
    endtask

    initial begin
        RST = 1'b1; start = 1'b0; load_partials = 1'b0; base_addr = 16'h0;
        fifo_has_space = 1'b1; mem_rvalid = 1'b0; mem_rdata = 64'd0;
        repeat (2) @(posedge CLK);
        #1;
        check_idle_outputs("reset");
        RST = 1'b0;

        run_seq(16'h0010, 1'b0, 1'b0, 1'b0, -1);
        run_seq(16'h0010, 1'b1, 1'b0, 1'b0, -1);
        run_seq(16'h0010, 1'b0, 1'b1, 1'b0, -1);
        run_seq(16'h0010, 1'b0, 1'b0, 1'b0, 13);
        run_seq(16'hFFFE, 1'b0, 1'b0, 1'b1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
